// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared widths and FSM state type for the banked SRAM
//                controller and its bank wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Controller states: zero-fill sequence, then normal operation
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    // Word address width across the whole banked space
    function automatic int addr_w(input int nb, input int depth);
        return $clog2(nb * depth);
    endfunction

    // Word address width inside one bank
    function automatic int word_w(input int depth);
        return $clog2(depth);
    endfunction

    // Bank-index width; kept at least 1 so a single-bank build still has a field
    function automatic int bank_w(input int nb, input int depth);
        int w;
        w = addr_w(nb, depth) - word_w(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // One byte-enable per data byte
    function automatic int be_w(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank_wrap
//  Description : One single-port SRAM bank with active-low csb/web, byte
//                write mask and one-cycle registered read data. Uses the
//                sky130 macro when available and shape-compatible, else a
//                behavioural array with identical timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_wrap
    import sram_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int DATA_W    = 32,
    parameter int USE_MACRO = 1
) (
`ifdef USE_POWER_PINS
    inout  wire                          VPWR,
    inout  wire                          VGND,
`endif
    input  logic                         clk,
    input  logic                         i_csb_n,
    input  logic                         i_web_n,
    input  logic [be_w(DATA_W)-1:0]      i_wmask,
    input  logic [word_w(DEPTH)-1:0]     i_addr,
    input  logic [DATA_W-1:0]            i_din,
    output logic [DATA_W-1:0]            o_dout
);

    localparam int c_bew = be_w(DATA_W);

    // The macro model is only present in builds that provide it
`ifdef SRAM_SKY130_MACRO
    localparam bit c_macro_avail = 1'b1;
`else
    localparam bit c_macro_avail = 1'b0;
`endif

    // The macro is fixed at 1024 x 32; any other shape falls back to the array
    localparam bit c_use_macro = (USE_MACRO != 0) && c_macro_avail &&
                                 (DATA_W == 32) && (DEPTH == 1024);

    if (c_use_macro) begin : g_macro
`ifdef SRAM_SKY130_MACRO
        sky130_sram_4kbyte_1rw1r_32x1024_8 u_macro (
`ifdef USE_POWER_PINS
            .vccd1  (VPWR),
            .vssd1  (VGND),
`endif
            .clk0   (clk),
            .csb0   (i_csb_n),
            .web0   (i_web_n),
            .wmask0 (i_wmask),
            .addr0  (i_addr),
            .din0   (i_din),
            .dout0  (o_dout),
            .clk1   (1'b0),
            .csb1   (1'b1),
            .addr1  (10'd0),
            .dout1  ()
        );
`endif
    end else begin : g_behav
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_dout;

        // Byte-masked write or registered read on an enabled cycle
        always_ff @(posedge clk) begin
            if (!i_csb_n) begin
                if (!i_web_n) begin
                    for (int i = 0; i < c_bew; i++) begin
                        if (i_wmask[i]) begin
                            r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
                        end
                    end
                end else begin
                    r_dout <= r_mem[i_addr];
                end
            end
        end

        assign o_dout = r_dout;
    end

endmodule
`default_nettype wire

// File: rtl/sram_banked_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_banked_ctrl
//  Description : Banked single-port SRAM subsystem with req/gnt/rvalid core
//                handshake, out-of-range error flagging and an optional
//                post-reset zero-fill of every bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_banked_ctrl
    import sram_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int BANK_DEPTH = 1024,
    parameter int DATA_W     = 32,
    parameter int INIT_ZERO  = 1,
    parameter int USE_MACRO  = 1
) (
`ifdef USE_POWER_PINS
    inout  wire                                     VPWR,
    inout  wire                                     VGND,
`endif
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    req_i,
    input  logic                                    we_i,
    input  logic [be_w(DATA_W)-1:0]                 be_i,
    input  logic [addr_w(NUM_BANKS, BANK_DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]                       wdata_i,
    output logic                                    gnt_o,
    output logic                                    rvalid_o,
    output logic [DATA_W-1:0]                       rdata_o,
    output logic                                    err_o,
    output logic                                    init_done_o
);

    localparam int c_aw  = addr_w(NUM_BANKS, BANK_DEPTH);
    localparam int c_bw  = word_w(BANK_DEPTH);
    localparam int c_bkw = bank_w(NUM_BANKS, BANK_DEPTH);
    localparam int c_bew = be_w(DATA_W);
    localparam logic [c_bw-1:0] c_last_word = c_bw'(BANK_DEPTH - 1);

    sram_state_e        r_state;
    logic [c_bw-1:0]    r_init_cnt;
    logic               r_init_done;
    logic               r_rvalid;
    logic               r_err;
    logic               r_rd;
    logic [c_bkw-1:0]   r_bank;

    logic [c_bkw-1:0]   w_bank;
    logic [c_bw-1:0]    w_word;
    logic               w_oor;
    logic               w_ready;
    logic               w_acc;
    logic [NUM_BANKS-1:0] w_csb_n;
    logic               w_web_n;
    logic [c_bew-1:0]   w_wmask;
    logic [c_bw-1:0]    w_baddr;
    logic [DATA_W-1:0]  w_din;
    logic [DATA_W-1:0]  w_dout [NUM_BANKS];
    logic [DATA_W-1:0]  w_rdata;

    // Address split; a single-bank build has no bank field in the address
    if (c_aw > c_bw) begin : g_bank_field
        assign w_bank = addr_i[c_aw-1:c_bw];
    end else begin : g_single_bank
        assign w_bank = '0;
    end

    assign w_word  = addr_i[c_bw-1:0];
    assign w_oor   = (int'(w_bank) >= NUM_BANKS);
    assign w_ready = (r_state == READY);
    assign gnt_o   = w_ready & req_i;
    assign w_acc   = gnt_o & ~w_oor & ~rst_i;

    // Bank port steering: all banks zero-filled in INIT, one bank per access in READY
    always_comb begin
        w_csb_n = '1;
        w_web_n = 1'b1;
        w_wmask = be_i;
        w_baddr = w_word;
        w_din   = wdata_i;
        if (!rst_i) begin
            if (!w_ready) begin
                w_csb_n = '0;
                w_web_n = 1'b0;
                w_wmask = '1;
                w_baddr = r_init_cnt;
                w_din   = '0;
            end else begin
                w_web_n = ~we_i;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (w_acc && (int'(w_bank) == b)) begin
                        w_csb_n[b] = 1'b0;
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank_wrap #(
            .DEPTH     (BANK_DEPTH),
            .DATA_W    (DATA_W),
            .USE_MACRO (USE_MACRO)
        ) u_bank (
`ifdef USE_POWER_PINS
            .VPWR    (VPWR),
            .VGND    (VGND),
`endif
            .clk     (clk_i),
            .i_csb_n (w_csb_n[b]),
            .i_web_n (w_web_n),
            .i_wmask (w_wmask),
            .i_addr  (w_baddr),
            .i_din   (w_din),
            .o_dout  (w_dout[b])
        );
    end

    // Controller FSM: init counter, ready flag and registered response qualifiers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= (INIT_ZERO != 0) ? INIT : READY;
            r_init_cnt  <= '0;
            r_init_done <= (INIT_ZERO == 0);
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rd        <= 1'b0;
            r_bank      <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    r_rvalid   <= 1'b0;
                    r_err      <= 1'b0;
                    r_rd       <= 1'b0;
                    if (r_init_cnt == c_last_word) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_rvalid <= req_i;
                    r_err    <= req_i & w_oor;
                    r_rd     <= req_i & ~we_i & ~w_oor;
                    r_bank   <= w_bank;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // Read data comes from the bank captured at grant, not the live address
    always_comb begin
        w_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(r_bank) == b) begin
                w_rdata = w_dout[b];
            end
        end
    end

    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign rdata_o     = r_rd ? w_rdata : '0;
    assign init_done_o = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_banked_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_banked_ctrl
//  Description : Scoreboard bench for sram_banked_ctrl (3 banks x 1024 x 32)
//                with a flat-array reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_banked_ctrl;

    localparam int NB    = 3;
    localparam int DEPTH = 1024;
    localparam int DW    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        init_done_o;

    sram_banked_ctrl #(
        .NUM_BANKS  (NB),
        .BANK_DEPTH (DEPTH),
        .DATA_W     (DW),
        .INIT_ZERO  (1),
        .USE_MACRO  (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .init_done_o (init_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          c;
        bit          err;
        logic [31:0] data;
        logic [11:0] a;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [NB*DEPTH];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response must arrive exactly one cycle after its grant
    exp_t e_mon;
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].c + 1 < cyc) begin
            e_mon = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_resp addr=%h: no rvalid in cycle %0d", e_mon.a, e_mon.c + 1);
        end
        if (q.size() > 0 && q[0].c + 1 == cyc) begin
            e_mon = q.pop_front();
            tests++;
            if (rvalid_o !== 1'b1 || err_o !== e_mon.err || rdata_o !== e_mon.data) begin
                fails++;
                $display("FAIL resp addr=%h: rvalid=%b err=%b rdata=%h, expected rvalid=1 err=%b rdata=%h",
                         e_mon.a, rvalid_o, err_o, rdata_o, e_mon.err, e_mon.data);
            end
        end else if (rvalid_o === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rvalid: rvalid=1 err=%b rdata=%h in cycle %0d with no grant pending",
                     err_o, rdata_o, cyc);
        end
    end

    // Present one cycle of stimulus; on a grant, predict the response
    task automatic issue(input bit r, input bit w, input logic [3:0] b,
                         input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        int   bank;
        @(posedge clk);
        #1;
        req = r; we = w; be = b; addr = a; wdata = d;
        #1;
        check(r ? "gnt_on_req" : "gnt_idle", 32'(gnt_o), r ? 32'd1 : 32'd0);
        if (r) begin
            e.c  = cyc;
            e.a  = a;
            bank = int'(a) / DEPTH;
            if (bank >= NB) begin
                e.err  = 1'b1;
                e.data = '0;
            end else begin
                e.err = 1'b0;
                if (w) begin
                    e.data = '0;
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
                    end
                end else begin
                    e.data = model[a];
                end
            end
            q.push_back(e);
        end
    endtask

    // Hold a request during zero-fill and measure its length from reset release
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 12'($urandom_range(0, 3071));
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done_o) break;
            if (n % 256 == 1) check("gnt_during_init", 32'(gnt_o), 32'd0);
        end
        req = 1'b0;
        check(nm, 32'(n), 32'd1024);
        for (int i = 0; i < NB*DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt",       32'(gnt_o),       32'd0);
        check("reset_rvalid",    32'(rvalid_o),    32'd0);
        check("reset_rdata",     rdata_o,          32'd0);
        check("reset_err",       32'(err_o),       32'd0);
        check("reset_init_done", 32'(init_done_o), 32'd0);
        rst = 1'b0;
        wait_init("init_length");

        // Zero-filled contents in every bank
        issue(1, 0, 4'h0, 12'h000, '0);
        issue(1, 0, 4'h0, 12'h7FF, '0);
        issue(1, 0, 4'h0, 12'hBFF, '0);

        // Write then read back
        issue(1, 1, 4'hF, 12'h005, 32'hDEADBEEF);
        issue(1, 0, 4'h0, 12'h005, '0);

        // Back-to-back reads alternating banks
        issue(1, 1, 4'hF, 12'h010, 32'hAAAAAAAA);
        issue(1, 1, 4'hF, 12'h410, 32'h55555555);
        issue(1, 0, 4'h0, 12'h010, '0);
        issue(1, 0, 4'h0, 12'h410, '0);
        issue(1, 0, 4'h0, 12'h010, '0);

        // Partial byte write
        issue(1, 1, 4'hF, 12'h020, 32'h11223344);
        issue(1, 1, 4'h5, 12'h020, 32'hFFFFFFFF);
        issue(1, 0, 4'h0, 12'h020, '0);

        // Out of range read and write, then a zero-byte-enable write
        issue(1, 0, 4'h0, 12'hC00, '0);
        issue(1, 1, 4'hF, 12'hC05, 32'hCAFEF00D);
        issue(1, 1, 4'h0, 12'h405, 32'h12345678);
        issue(1, 0, 4'h0, 12'h405, '0);
        issue(0, 0, 4'h0, 12'h000, '0);

        // Randomized traffic, biased toward a small reused window per bank
        for (int k = 0; k < 400; k++) begin
            logic [11:0] a;
            if ($urandom_range(0, 1) == 0) a = 12'($urandom_range(0, 4095));
            else a = 12'(($urandom_range(0, 3) << 10) | $urandom_range(0, 15));
            issue($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), a, $urandom);
        end
        issue(0, 0, 4'h0, 12'h000, '0);

        // Reset in the same cycle as a granted request drops its response
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 12'h005; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rvalid_after_reset", 32'(rvalid_o), 32'd0);
        rst = 1'b0;
        wait_init("init_length_after_reset");

        // Reset in the middle of zero-fill restarts it
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("init_done_mid_init", 32'(init_done_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("init_length_restart");

        // Previously written words are cleared again
        issue(1, 0, 4'h0, 12'h005, '0);
        issue(1, 0, 4'h0, 12'h010, '0);
        issue(1, 0, 4'h0, 12'h410, '0);
        issue(1, 0, 4'h0, 12'h020, '0);
        for (int k = 0; k < 40; k++) begin
            issue(1, 0, 4'h0, 12'(($urandom_range(0, 2) << 10) | $urandom_range(0, 15)), '0);
        end
        issue(0, 0, 4'h0, 12'h000, '0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
